sram_like_slave: RTL and testbench

- Responder end of the SRAM-like request/response interface driven by the fetch and memory stages (req/wr/size/addr/wstrb/wdata out, addr_ok/data_ok/rdata back).
- Backs a word-organised memory window starting at the reset fetch address 0x1c000000.
- Accepts requests under an address handshake and returns in-order responses after a configurable latency.
- Serves as the simulation target for the instruction and data ports, and as the template for the later AXI bridge front end.

---
 rtl/sram_like_slave_pkg.sv | 35 +++
 rtl/sram_like_slave_resp_queue.sv | 71 +++++++
 rtl/sram_like_slave.sv | 92 +++++++++
 tb/tb_sram_like_slave.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_like_slave_pkg.sv
// rtl/sram_like_slave_pkg.sv - shared encodings, widths and types for the SRAM-like slave
package sram_like_slave_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam logic [31:0] RESET_PC_BASE = 32'h1c000000;

    // {wr, size, addr, wstrb, wdata}
    localparam int SRAM_REQ_BUS_WD = 1 + 2 + 32 + 4 + 32;

    // Wide enough for the largest legal response delay (7).
    localparam int AGE_W = 3;

    typedef struct packed {
        logic [31:0]      data;
        logic [AGE_W-1:0] age;
    } q_entry_t;

    // Replace the byte lanes of old_word selected by strb with those of new_word.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_word;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sram_like_slave_resp_queue.sv
// rtl/sram_like_slave_resp_queue.sv - in-order response FIFO with per-entry age counters
//   clk, reset   : clock, synchronous active-high reset (empties the queue)
//   push         : enqueue push_data with age 1
//   pop          : dequeue the head (only when head_ready)
//   count        : occupancy at the start of the cycle
//   head_data    : snapshot held by the head entry
//   head_ready   : head exists and its age has reached RESP_DELAY
module sram_like_slave_resp_queue
    import sram_like_slave_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int RESP_DELAY = 1,
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [31:0]      push_data,
    input  logic             pop,
    output logic [CNT_W-1:0] count,
    output logic [31:0]      head_data,
    output logic             head_ready
);

    q_entry_t         ent     [DEPTH];
    q_entry_t         nxt     [DEPTH];
    logic [CNT_W-1:0] nxt_count;
    logic [CNT_W-1:0] tail;

    function automatic q_entry_t age_up(input q_entry_t e);
        q_entry_t r;
        r = e;
        if (e.age != AGE_W'(RESP_DELAY)) begin
            r.age = e.age + AGE_W'(1);
        end
        return r;
    endfunction

    // Entry 0 is always the head; a pop shifts everything down one slot.
    // Slots beyond count hold stale data and are overwritten on push.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            nxt[i] = age_up(ent[i]);
        end
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                nxt[i] = age_up(ent[i + 1]);
            end
        end
        tail = count - CNT_W'(pop);
        for (int i = 0; i < DEPTH; i++) begin
            if (push && (CNT_W'(i) == tail)) begin
                nxt[i] = '{data: push_data, age: AGE_W'(1)};
            end
        end
        nxt_count = count + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= nxt_count;
            ent   <= nxt;
        end
    end

    assign head_data  = ent[0].data;
    assign head_ready = (count != '0) && (ent[0].age == AGE_W'(RESP_DELAY));

endmodule

// File: rtl/sram_like_slave.sv
// rtl/sram_like_slave.sv - SRAM-like responder backing a word-organised memory window
//   clk, reset      : clock, synchronous active-high reset
//   req, wr, size   : request valid, write flag, access size (informational)
//   addr            : byte address; addr[1:0] ignored
//   wstrb, wdata    : write byte enables and data
//   addr_stall      : external backpressure, forces addr_ok low
//   addr_ok         : request accepted this cycle
//   data_ok, rdata  : in-order response strobe and data (0 for writes)
module sram_like_slave
    import sram_like_slave_pkg::*;
#(
    parameter int          ADDR_W          = 12,
    parameter logic [31:0] BASE_ADDR       = RESET_PC_BASE,
    parameter int          RESP_DELAY      = 1,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    input  logic        addr_stall,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [31:0]       mem [0:(1 << ADDR_W) - 1];

    logic [31:0]       off;
    logic              in_range;
    logic [ADDR_W-1:0] idx;
    logic [31:0]       snap;
    logic [CNT_W-1:0]  count;
    logic [31:0]       head_data;
    logic              head_ready;
    logic [31:0]       rdata_hold;
    logic              unused_ok;

    assign off      = addr - BASE_ADDR;
    assign in_range = (off >> (ADDR_W + 2)) == 32'd0;
    assign idx      = off[ADDR_W+1:2];

    // count is the start-of-cycle occupancy, so a same-cycle pop never frees
    // a slot for this cycle's accept.
    assign addr_ok = req && !reset && !addr_stall && (count < CNT_W'(MAX_OUTSTANDING));
    assign data_ok = !reset && head_ready;

    // Reads snapshot the word as it stands before this edge's write (only one
    // request per cycle, so there is no same-edge conflict).
    assign snap = (!wr && in_range) ? mem[idx] : 32'd0;

    always_ff @(posedge clk) begin
        if (addr_ok && wr && in_range) begin
            mem[idx] <= merge_bytes(mem[idx], wdata, wstrb);
        end
    end

    sram_like_slave_resp_queue #(
        .DEPTH      (MAX_OUTSTANDING),
        .RESP_DELAY (RESP_DELAY)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .push       (addr_ok),
        .push_data  (snap),
        .pop        (data_ok),
        .count      (count),
        .head_data  (head_data),
        .head_ready (head_ready)
    );

    // rdata shows the head snapshot in the response cycle and the last
    // delivered value otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_hold <= 32'd0;
        end else if (data_ok) begin
            rdata_hold <= head_data;
        end
    end

    assign rdata = data_ok ? head_data : rdata_hold;

    assign unused_ok = ^{size, off[1:0]};

endmodule

// File: tb/tb_sram_like_slave.sv
// tb/tb_sram_like_slave.sv - randomized self-checking bench for sram_like_slave (two configurations)
module tb_sram_like_slave;

    localparam logic [31:0] BASE = 32'h1c000000;
    localparam int RD0 = 1;
    localparam int MO0 = 2;
    localparam int RD1 = 4;
    localparam int MO1 = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        wr = 1'b0;
    logic [1:0]  size = 2'd2;
    logic [31:0] addr = BASE;
    logic [3:0]  wstrb = 4'h0;
    logic [31:0] wdata = 32'd0;
    logic        addr_stall = 1'b0;

    logic        aok0, dok0, aok1, dok1;
    logic [31:0] rd0, rd1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sram_like_slave #(.ADDR_W(12), .BASE_ADDR(BASE), .RESP_DELAY(RD0), .MAX_OUTSTANDING(MO0)) u_fast (
        .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .addr(addr),
        .wstrb(wstrb), .wdata(wdata), .addr_stall(addr_stall),
        .addr_ok(aok0), .data_ok(dok0), .rdata(rd0)
    );

    sram_like_slave #(.ADDR_W(12), .BASE_ADDR(BASE), .RESP_DELAY(RD1), .MAX_OUTSTANDING(MO1)) u_slow (
        .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .addr(addr),
        .wstrb(wstrb), .wdata(wdata), .addr_stall(addr_stall),
        .addr_ok(aok1), .data_ok(dok1), .rdata(rd1)
    );

    // Reference model: each accepted request is due exactly RESP_DELAY cycles
    // after its accept cycle; responses leave in order from a circular list.
    int          cyc = 0;
    int          m_cnt  [2];
    int          m_head [2];
    int          m_due  [2][8];
    logic [31:0] m_dat  [2][8];
    logic [31:0] m_last [2];
    logic [31:0] m_mem  [2][4096];
    logic        exp_acc [2];
    logic        obs_aok [2];
    logic        obs_dok [2];
    logic [31:0] obs_rd  [2];

    function automatic int rd_of(input int i);
        return (i == 0) ? RD0 : RD1;
    endfunction

    function automatic int mo_of(input int i);
        return (i == 0) ? MO0 : MO1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle with the inputs as currently driven.
    task automatic cycle();
        logic        e_aok, e_dok;
        logic [31:0] off, word;
        int          w, slot;
        @(negedge clk);
        obs_aok[0] = aok0; obs_dok[0] = dok0; obs_rd[0] = rd0;
        obs_aok[1] = aok1; obs_dok[1] = dok1; obs_rd[1] = rd1;
        for (int i = 0; i < 2; i++) begin
            e_aok = !reset && req && !addr_stall && (m_cnt[i] < mo_of(i));
            e_dok = !reset && (m_cnt[i] > 0) && (m_due[i][m_head[i]] == cyc);
            exp_acc[i] = e_aok;
            check($sformatf("addr_ok%0d@%0d", i, cyc), {31'd0, obs_aok[i]}, {31'd0, e_aok});
            check($sformatf("data_ok%0d@%0d", i, cyc), {31'd0, obs_dok[i]}, {31'd0, e_dok});
            if (!reset) begin
                check($sformatf("rdata%0d@%0d", i, cyc), obs_rd[i],
                      e_dok ? m_dat[i][m_head[i]] : m_last[i]);
            end
            if (reset) begin
                m_cnt[i]  = 0;
                m_head[i] = 0;
                m_last[i] = 32'd0;
            end else begin
                if (e_dok) begin
                    m_last[i] = m_dat[i][m_head[i]];
                    m_head[i] = (m_head[i] + 1) % 8;
                    m_cnt[i]--;
                end
                if (e_aok) begin
                    off  = addr - BASE;
                    w    = int'(off[13:2]);
                    word = 32'd0;
                    if (off < 32'h4000) begin
                        if (wr) begin
                            for (int b = 0; b < 4; b++) begin
                                if (wstrb[b]) m_mem[i][w][8*b +: 8] = wdata[8*b +: 8];
                            end
                        end else begin
                            word = m_mem[i][w];
                        end
                    end
                    slot = (m_head[i] + m_cnt[i]) % 8;
                    m_due[i][slot] = cyc + rd_of(i);
                    m_dat[i][slot] = word;
                    m_cnt[i]++;
                end
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req = 1'b0;
        repeat (n) cycle();
    endtask

    task automatic set_req(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        req = 1'b1; wr = w; addr = a; wstrb = s; wdata = d; size = 2'd2;
    endtask

    // Hold a request until both instances have taken it; a repeated accept
    // of the same request is harmless and is modelled like any other.
    task automatic do_req(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        logic got0, got1;
        got0 = 1'b0; got1 = 1'b0;
        set_req(w, a, s, d);
        for (int k = 0; k < 30 && !(got0 && got1); k++) begin
            cycle();
            got0 |= exp_acc[0];
            got1 |= exp_acc[1];
        end
        check("do_req_accept", {31'd0, got0 && got1}, 32'd1);
        req = 1'b0;
    endtask

    int acc_cnt, dok_cnt, tot_acc;
    logic [31:0] v;

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_head[i] = 0; m_last[i] = 32'd0;
            for (int w = 0; w < 4096; w++) m_mem[i][w] = 32'd0;
        end

        // Reset state
        repeat (2) cycle();
        reset = 1'b0;
        cycle();
        check("reset_rdata0", rd0, 32'd0);
        check("reset_rdata1", rd1, 32'd0);

        // Preload words 0..15 through the front door
        for (int w = 0; w < 16; w++) begin
            v = (w == 0) ? 32'h02800000 : (w == 1) ? 32'h02800421 :
                (w == 4) ? 32'h11223344 : $urandom;
            do_req(1'b1, BASE + 32'(4 * w), 4'hf, v);
        end
        idle(8);

        // Fetch stream at RESP_DELAY=1
        set_req(1'b0, 32'h1c000000, 4'h0, 32'd0);
        cycle();
        check("fetch_aok_a", {31'd0, obs_aok[0]}, 32'd1);
        set_req(1'b0, 32'h1c000004, 4'h0, 32'd0);
        cycle();
        check("fetch_aok_b", {31'd0, obs_aok[0]}, 32'd1);
        check("fetch_rd_a", obs_rd[0], 32'h02800000);
        idle(1);
        check("fetch_dok_b", {31'd0, obs_dok[0]}, 32'd1);
        check("fetch_rd_b", obs_rd[0], 32'h02800421);
        idle(8);

        // Byte write then read
        do_req(1'b1, 32'h1c000010, 4'b0010, 32'h0000AB00);
        idle(8);
        set_req(1'b0, 32'h1c000010, 4'h0, 32'd0);
        cycle();
        idle(1);
        check("byte_merge", obs_rd[0], 32'h1122AB44);
        idle(8);

        // Backpressure on the slow instance
        acc_cnt = 0; tot_acc = 0; dok_cnt = 0;
        set_req(1'b0, 32'h1c000008, 4'h0, 32'd0);
        for (int k = 0; k < 12; k++) begin
            cycle();
            if (k < 5) acc_cnt += int'(obs_aok[1]);
            tot_acc += int'(obs_aok[1]);
            dok_cnt += int'(obs_dok[1]);
        end
        req = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            dok_cnt += int'(obs_dok[1]);
        end
        check("bp_first_accepts", 32'(acc_cnt), 32'd2);
        check("bp_no_loss", 32'(dok_cnt), 32'(tot_acc));

        // addr_stall
        set_req(1'b0, 32'h1c000004, 4'h0, 32'd0);
        addr_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("stall_aok", {31'd0, obs_aok[0]}, 32'd0);
        end
        addr_stall = 1'b0;
        cycle();
        check("stall_release_aok", {31'd0, obs_aok[0]}, 32'd1);
        idle(1);
        check("stall_rd", obs_rd[0], 32'h02800421);
        idle(8);

        // Out of range
        set_req(1'b0, 32'h1bfffffc, 4'h0, 32'd0);
        cycle();
        idle(1);
        check("oor_rd_dok", {31'd0, obs_dok[0]}, 32'd1);
        check("oor_rd_zero", obs_rd[0], 32'd0);
        idle(8);
        do_req(1'b1, 32'h1c004000, 4'hf, 32'hdeadbeef);
        idle(8);
        set_req(1'b0, 32'h1c000000, 4'h0, 32'd0);
        cycle();
        idle(1);
        check("oor_wr_mem_kept", obs_rd[0], 32'h02800000);
        idle(8);

        // Reset mid-flight on the slow instance
        set_req(1'b0, 32'h1c000000, 4'h0, 32'd0);
        cycle();
        set_req(1'b0, 32'h1c000004, 4'h0, 32'd0);
        cycle();
        idle(1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        dok_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            cycle();
            dok_cnt += int'(obs_dok[1]);
        end
        check("rst_no_dok", 32'(dok_cnt), 32'd0);
        set_req(1'b0, 32'h1c000010, 4'h0, 32'd0);
        cycle();
        idle(1);
        check("rst_mem_kept", obs_rd[0], 32'h1122AB44);
        idle(8);

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            req        = ($urandom % 4) != 0;
            wr         = ($urandom % 3) == 0;
            addr_stall = ($urandom % 8) == 0;
            reset      = ($urandom % 100) == 0;
            size       = 2'($urandom % 3);
            wstrb      = 4'($urandom);
            wdata      = $urandom;
            case ($urandom % 10)
                0:       addr = 32'h1bfffffc - 32'(4 * ($urandom % 4));
                1:       addr = 32'h1c004000 + 32'(4 * ($urandom % 4));
                default: addr = BASE + 32'(4 * ($urandom % 16)) + 32'($urandom % 4);
            endcase
            cycle();
        end
        reset = 1'b0;
        addr_stall = 1'b0;
        idle(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
